// File: rtl/agu_sched_if.sv
// agu_sched_if: requester, flush and result signals of the shared address adder
interface agu_sched_if #(parameter int TAG_W = 4);
  logic flush;
  logic ctl_valid, ctl_ready, ctl_use_reg;
  logic [31:0] ctl_pc, ctl_rs1, ctl_imm;
  logic [TAG_W-1:0] ctl_tag;
  logic mem_valid, mem_ready;
  logic [31:0] mem_rs1, mem_imm;
  logic [1:0] mem_size;
  logic [TAG_W-1:0] mem_tag;
  logic out_valid, out_ready, out_src, out_misalign;
  logic [31:0] out_addr;
  logic [TAG_W-1:0] out_tag;
  modport master (
    output flush, ctl_valid, ctl_use_reg, ctl_pc, ctl_rs1, ctl_imm, ctl_tag,
           mem_valid, mem_rs1, mem_imm, mem_size, mem_tag, out_ready,
    input  ctl_ready, mem_ready, out_valid, out_addr, out_src, out_tag, out_misalign
  );
  modport slave (
    input  flush, ctl_valid, ctl_use_reg, ctl_pc, ctl_rs1, ctl_imm, ctl_tag,
           mem_valid, mem_rs1, mem_imm, mem_size, mem_tag, out_ready,
    output ctl_ready, mem_ready, out_valid, out_addr, out_src, out_tag, out_misalign
  );
endinterface

// File: rtl/agu_sched.sv
// agu_sched: arbitrates CTL/MEM requests onto one 32-bit adder, registers address and misalign flag
module agu_sched #(
  parameter int STARVE_LIMIT = 3,
  parameter int TAG_W        = 4,
  parameter int IALIGN       = 4
) (
  input logic        clk,
  input logic        reset_n,
  agu_sched_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  localparam logic [31:0] AMASK = 32'(IALIGN - 1);
  logic [CW-1:0] starve_cnt;
  logic accept, grant_ctl, grant_mem, jalr, misalign;
  logic [31:0] base, off, sum, addr;
  always_comb begin
    accept    = !bus.flush && (!bus.out_valid || bus.out_ready);
    grant_mem = accept && bus.mem_valid && (!bus.ctl_valid || starve_cnt == LIM);
    grant_ctl = accept && bus.ctl_valid && !grant_mem;
    jalr      = !grant_mem && bus.ctl_use_reg;
    base      = grant_mem ? bus.mem_rs1 : (bus.ctl_use_reg ? bus.ctl_rs1 : bus.ctl_pc);
    off       = grant_mem ? bus.mem_imm : bus.ctl_imm;
    sum       = base + off;
    addr      = jalr ? {sum[31:1], 1'b0} : sum;
    misalign  = !grant_mem ? ((addr & AMASK) != 32'd0) :
                bus.mem_size == 2'd0 ? 1'b0 :
                bus.mem_size == 2'd1 ? addr[0] : (addr[1:0] != 2'd0);
  end
  assign bus.ctl_ready = grant_ctl;
  assign bus.mem_ready = grant_mem;
  // Count resets whenever MEM is not actually waiting, so it only measures a live starvation run
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) starve_cnt <= '0;
    else if (bus.flush || !bus.mem_valid || grant_mem) starve_cnt <= '0;
    else if (grant_ctl && starve_cnt != LIM) starve_cnt <= starve_cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid    <= 1'b0;
      bus.out_addr     <= '0;
      bus.out_src      <= 1'b0;
      bus.out_tag      <= '0;
      bus.out_misalign <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (grant_ctl || grant_mem) begin
      bus.out_valid    <= 1'b1;
      bus.out_addr     <= addr;
      bus.out_src      <= grant_mem;
      bus.out_tag      <= grant_mem ? bus.mem_tag : bus.ctl_tag;
      bus.out_misalign <= misalign;
    end else if (accept) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_agu_sched.sv
// tb_agu_sched: directed vectors for agu_sched with hand-computed expectations
module tb_agu_sched;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  agu_sched_if #(.TAG_W(4)) bus ();
  agu_sched #(.STARVE_LIMIT(3), .TAG_W(4), .IALIGN(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.ctl_valid = 1'b0;
    bus.mem_valid = 1'b0;
  endtask
  task automatic ctl(input logic ur, input logic [31:0] pc, input logic [31:0] rs1,
                     input logic [31:0] imm, input logic [3:0] tag);
    bus.ctl_valid = 1'b1; bus.ctl_use_reg = ur; bus.ctl_pc = pc;
    bus.ctl_rs1 = rs1; bus.ctl_imm = imm; bus.ctl_tag = tag;
  endtask
  task automatic mem(input logic [31:0] rs1, input logic [31:0] imm, input logic [1:0] sz,
                     input logic [3:0] tag);
    bus.mem_valid = 1'b1; bus.mem_rs1 = rs1; bus.mem_imm = imm;
    bus.mem_size = sz; bus.mem_tag = tag;
  endtask
  task automatic out_chk(input string t, input logic [31:0] a, input logic s,
                         input logic [3:0] tg, input logic m);
    chk({t, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({t, "_addr"}, bus.out_addr, a);
    chk({t, "_src"}, 32'(bus.out_src), 32'(s));
    chk({t, "_tag"}, 32'(bus.out_tag), 32'(tg));
    chk({t, "_mis"}, 32'(bus.out_misalign), 32'(m));
  endtask
  initial begin
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    bus.ctl_use_reg = 1'b0; bus.ctl_pc = '0; bus.ctl_rs1 = '0; bus.ctl_imm = '0; bus.ctl_tag = '0;
    bus.mem_rs1 = '0; bus.mem_imm = '0; bus.mem_size = '0; bus.mem_tag = '0;
    idle();
    #3;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_addr", bus.out_addr, 32'd0);
    chk("rst_src", 32'(bus.out_src), 32'd0);
    chk("rst_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_mis", 32'(bus.out_misalign), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    cyc();
    // CTL only
    ctl(1'b0, 32'h100, 32'h0, 32'hFFFF_FFF8, 4'd1);
    #1;
    chk("ctl_rdy", 32'(bus.ctl_ready), 32'd1);
    chk("ctl_mrdy", 32'(bus.mem_ready), 32'd0);
    cyc();
    out_chk("jal", 32'hF8, 1'b0, 4'd1, 1'b0);
    ctl(1'b1, 32'h0, 32'h203, 32'h0, 4'd2);
    cyc();
    out_chk("jalr", 32'h202, 1'b0, 4'd2, 1'b1);
    idle();
    cyc();
    chk("idle_valid", 32'(bus.out_valid), 32'd0);
    // MEM sizes and wrap-around
    mem(32'h1001, 32'h0, 2'd1, 4'd3); cyc(); out_chk("half", 32'h1001, 1'b1, 4'd3, 1'b1);
    mem(32'h1000, 32'h4, 2'd2, 4'd4); cyc(); out_chk("word", 32'h1004, 1'b1, 4'd4, 1'b0);
    mem(32'h1003, 32'h0, 2'd0, 4'd5); cyc(); out_chk("byte", 32'h1003, 1'b1, 4'd5, 1'b0);
    mem(32'hFFFF_FFFC, 32'h8, 2'd2, 4'd6); cyc(); out_chk("wrap", 32'h4, 1'b1, 4'd6, 1'b0);
    mem(32'h1002, 32'h0, 2'd3, 4'd7); cyc(); out_chk("rsvd", 32'h1002, 1'b1, 4'd7, 1'b1);
    idle();
    cyc();
    // Both valid: C,C,C,M pattern
    ctl(1'b0, 32'h400, 32'h0, 32'h20, 4'd5);
    mem(32'h2000, 32'h10, 2'd2, 4'd10);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("arb%0d_c", i), 32'(bus.ctl_ready), 32'(i % 4 != 3));
      chk($sformatf("arb%0d_m", i), 32'(bus.mem_ready), 32'(i % 4 == 3));
      cyc();
      chk($sformatf("arb%0d_src", i), 32'(bus.out_src), 32'(i % 4 == 3));
      chk($sformatf("arb%0d_tag", i), 32'(bus.out_tag), (i % 4 == 3) ? 32'd10 : 32'd5);
    end
    // Backpressure: M result held for 5 cycles
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp%0d_crdy", i), 32'(bus.ctl_ready), 32'd0);
      chk($sformatf("bp%0d_mrdy", i), 32'(bus.mem_ready), 32'd0);
      cyc();
      out_chk($sformatf("bp%0d", i), 32'h2010, 1'b1, 4'd10, 1'b0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("rel_crdy", 32'(bus.ctl_ready), 32'd1);
    cyc();
    out_chk("rel", 32'h420, 1'b0, 4'd5, 1'b0);
    cyc();
    // Flush with out_valid=1, out_ready=1, starve count at 2
    bus.flush = 1'b1;
    #1;
    chk("fl_crdy", 32'(bus.ctl_ready), 32'd0);
    chk("fl_mrdy", 32'(bus.mem_ready), 32'd0);
    cyc();
    chk("fl_valid", 32'(bus.out_valid), 32'd0);
    bus.flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("pf%0d_c", i), 32'(bus.ctl_ready), 32'(i != 3));
      chk($sformatf("pf%0d_m", i), 32'(bus.mem_ready), 32'(i == 3));
      cyc();
    end
    // Asynchronous reset mid-stream
    reset_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_addr", bus.out_addr, 32'd0);
    chk("ar_src", 32'(bus.out_src), 32'd0);
    chk("ar_tag", 32'(bus.out_tag), 32'd0);
    idle();
    @(negedge clk) reset_n = 1'b1;
    cyc();
    mem(32'h1000, 32'h0, 2'd2, 4'd7);
    #1;
    chk("ar_mrdy", 32'(bus.mem_ready), 32'd1);
    chk("ar_pre_valid", 32'(bus.out_valid), 32'd0);
    cyc();
    out_chk("ar_first", 32'h1000, 1'b1, 4'd7, 1'b0);
    idle();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
